an_encoder_52bits: RTL and testbench
====================================

# an_encoder_52bits

Sequential AN-code encoder for the 52-bit trade-off datapath: accepts a data word N, forms the codeword W = A·N by shift-add multiplication, and presents W to the downstream trade-off decoder. It sits directly upstream of the decoder and uses the same A, W_BITS and N_BITS. A compile-time option adds a single arithmetic-error injector, so decoder correction can be exercised end to end.

## Interface
- A, 50861: AN-code constant; must equal the decoder's A
- A_BITS, 16: width of A
- N_BITS, 53: data width, matching the decoder's N output
- W_BITS, 69: codeword width, equal to N_BITS+A_BITS; cannot overflow
- L_BITS, 7: width of the error-position field
- clk  in  1  clock, rising-edge only
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  N is valid
- in_ready  out  1  encoder can accept N
- N  in  N_BITS  data word
- out_valid  out  1  W is valid
- out_ready  in  1  consumer takes W
- W  out  W_BITS  codeword
- N_out  out  N_BITS  N that produced W, for checking
- err_en  in  1  inject error on this word (ERR_INJ_EN only)
- err_pos  in  L_BITS  error bit position 0..W_BITS-1 (ERR_INJ_EN only)
- err_sign  in  1  1 adds the error, 0 subtracts it (ERR_INJ_EN only)

## Operation
- FSM states: IDLE, MUL, INJ, HOLD.
- IDLE: in_ready=1. When in_valid is high:
  - latch N into mcand (zero-extended to W_BITS) and into N_out
  - latch A into mplier; clear acc and the 5-bit cnt
  - latch err_en, err_pos and err_sign
  - go to MUL
- MUL, one bit per cycle:
  - if mplier[0], acc <= acc + mcand
  - mcand <<= 1; mplier >>= 1; cnt++
  - after the cycle where cnt==A_BITS-1, go to INJ
- INJ:
  - with err_en latched and err_pos < W_BITS: acc <= acc ± (1<<err_pos), modulo 2^W_BITS. Plus when err_sign=1, minus when err_sign=0.
  - err_pos ≥ W_BITS: no injection.
  - go to HOLD.
- HOLD: out_valid=1; W=acc. When out_ready is high, go to IDLE.
- W, N_out and out_valid stay stable while out_valid is high and out_ready is low.
- Arithmetic: A·N < 2^W_BITS, so the uninjected W is exact. A negative injection onto W=0 wraps to 2^W_BITS-(1<<err_pos). That wrap is deliberate and not flagged.
- The injection matches the decoder's error model: err_pos p corresponds to decoder location l = ±(p+1).

## Timing
- Reset values:
  - state=IDLE
  - in_ready=1, out_valid=0
  - W=0, N_out=0
  - acc, mcand, mplier and cnt all 0
- Accept at edge k. MUL occupies edges k+1..k+16, INJ is edge k+17, and out_valid rises after edge k+17. Latency is 17 cycles.
- Handshake: a transfer happens when valid && ready at a rising edge.
- in_ready is low from the accept edge until the cycle after the out_valid/out_ready transfer. There is no bypass; one word is in flight at most. Peak throughput is one word per 19 cycles.
- rst high during any state returns to IDLE with reset values at the next edge. A partial product is discarded and never output.
- Error inputs are sampled only at the accept edge.

## Configuration
- ERR_INJ_EN defined: the err_* ports and the INJ arithmetic exist.
- ERR_INJ_EN undefined:
  - err_* ports are absent
  - INJ is a pass-through cycle with unchanged latency
  - W = A·N always

## Structure
- Shared package an52_pkg holds:
  - A, A_BITS, N_BITS, W_BITS, L_BITS
  - the state enum
  - the decoder-location↔bit-position conversion constant (offset 1)
- A single sub-module, an_shift_add_mul, holds acc, mcand, mplier and cnt, with start/done handshake. The top holds the FSM, handshake and injector.

## Test plan
- N=1, out_ready=1 → W=50861 and N_out=1; out_valid rises 17 cycles after accept.
- N=0 → W=0. N=2^53-1 → W=50861·(2^53-1) exactly, compared with a 69-bit reference model.
- ERR_INJ_EN, N=5, err_en=1, err_pos=3, err_sign=1 → W=254313. err_pos=0, err_sign=0 → W=254304. err_pos=69 → W=254305.
- HOLD with out_ready low for 10 cycles while in_valid is high → W and N_out stable, in_ready=0, no second accept. A new accept happens the cycle after release.
- rst pulsed mid-MUL at cycle 8 → outputs return to reset values. The next N=2 gives W=101722 with normal latency.
- Back-to-back 1000 random N with random err_* fed into the trade-off decoder → the decoder's N equals N_out for every word.

Source files
------------

// File: rtl/an52_pkg.sv
// Shared constants, state encoding and error-model helpers for the 52-bit AN-code datapath.
// Also used by the trade-off decoder, so A and all widths must stay identical on both sides.
package an52_pkg;

    localparam int unsigned A_BITS   = 16;
    localparam int unsigned N_BITS   = 53;
    localparam int unsigned W_BITS   = N_BITS + A_BITS;
    localparam int unsigned L_BITS   = 7;
    localparam int unsigned CNT_BITS = 5;

    localparam logic [A_BITS-1:0] A = 16'd50861;

    // Decoder location l = +/-(p + LOC_OFFSET) for error bit position p.
    localparam int unsigned LOC_OFFSET = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        INJ  = 2'd2,
        HOLD = 2'd3
    } state_e;

    typedef struct packed {
        logic              en;
        logic [L_BITS-1:0] pos;
        logic              sign;
    } err_req_t;

    function automatic logic [L_BITS-1:0] loc_to_pos(input logic [L_BITS-1:0] loc_mag);
        return loc_mag - L_BITS'(LOC_OFFSET);
    endfunction

    function automatic logic [L_BITS-1:0] pos_to_loc(input logic [L_BITS-1:0] pos);
        return pos + L_BITS'(LOC_OFFSET);
    endfunction

endpackage

// File: rtl/an_shift_add_mul.sv
// Sequential shift-add multiplier forming A*N, one multiplier bit per cycle.
// start_i loads a fresh operand; done_c is high during the final step.
module an_shift_add_mul
    import an52_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [N_BITS-1:0] n_i,
    output logic [W_BITS-1:0] acc_o,
    output logic              done_c
);

    logic [W_BITS-1:0]   acc_q,    acc_d;
    logic [W_BITS-1:0]   mcand_q,  mcand_d;
    logic [A_BITS-1:0]   mplier_q, mplier_d;
    logic [CNT_BITS-1:0] cnt_q,    cnt_d;
    logic                busy_q,   busy_d;

    logic last_step_c;

    assign last_step_c = busy_q && (cnt_q == CNT_BITS'(A_BITS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start_i) begin
            acc_d    = '0;
            mcand_d  = W_BITS'(n_i);
            mplier_d = A;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_BITS'(1);
            if (last_step_c) begin
                busy_d = 1'b0;
            end
        end
    end

    assign acc_o  = acc_q;
    assign done_c = last_step_c;

endmodule

// File: rtl/an_encoder_52bits.sv
// AN-code encoder W = A*N with valid/ready handshakes and one word in flight.
// Optional macro ERR_INJ_EN adds a single +/-2^p arithmetic-error injector in the INJ cycle.
module an_encoder_52bits
    import an52_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
`ifdef ERR_INJ_EN
    input  logic              err_en,
    input  logic [L_BITS-1:0] err_pos,
    input  logic              err_sign,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_BITS-1:0] N,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W_BITS-1:0] W,
    output logic [N_BITS-1:0] N_out
);

    state_e            state_q,     state_d;
    logic              in_ready_q,  in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [W_BITS-1:0] w_q,         w_d;
    logic [N_BITS-1:0] n_out_q,     n_out_d;

    logic              mul_start_c;
    logic              mul_done_c;
    logic [W_BITS-1:0] mul_acc;

`ifdef ERR_INJ_EN
    err_req_t          err_q, err_d;
    logic [W_BITS-1:0] inj_c;

    assign inj_c = W_BITS'(1) << err_q.pos;
`endif

    an_shift_add_mul u_mul (
        .clk     (clk),
        .rst     (rst),
        .start_i (mul_start_c),
        .n_i     (N),
        .acc_o   (mul_acc),
        .done_c  (mul_done_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            w_q         <= '0;
            n_out_q     <= '0;
`ifdef ERR_INJ_EN
            err_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            w_q         <= w_d;
            n_out_q     <= n_out_d;
`ifdef ERR_INJ_EN
            err_q       <= err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        w_d         = w_q;
        n_out_d     = n_out_q;
        mul_start_c = 1'b0;
`ifdef ERR_INJ_EN
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    n_out_d     = N;
                    mul_start_c = 1'b1;
                    in_ready_d  = 1'b0;
`ifdef ERR_INJ_EN
                    err_d.en    = err_en;
                    err_d.pos   = err_pos;
                    err_d.sign  = err_sign;
`endif
                    state_d     = MUL;
                end
            end
            MUL: begin
                if (mul_done_c) begin
                    state_d = INJ;
                end
            end
            INJ: begin
                // Out-of-range positions leave the product untouched; negative wrap is intended.
`ifdef ERR_INJ_EN
                if (err_q.en && (err_q.pos < L_BITS'(W_BITS))) begin
                    w_d = err_q.sign ? (mul_acc + inj_c) : (mul_acc - inj_c);
                end else begin
                    w_d = mul_acc;
                end
`else
                w_d = mul_acc;
`endif
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign W         = w_q;
    assign N_out     = n_out_q;

endmodule

// File: tb/tb_an_encoder_52bits.sv
// Scoreboard bench for an_encoder_52bits: the driver pushes expected codewords,
// and a monitor pops and compares them at each output transfer.
module tb_an_encoder_52bits;
    import an52_pkg::*;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [N_BITS-1:0] N;
    logic              out_valid;
    logic              out_ready;
    logic [W_BITS-1:0] W;
    logic [N_BITS-1:0] N_out;
    logic              err_en;
    logic [L_BITS-1:0] err_pos;
    logic              err_sign;

    typedef struct packed {
        logic [W_BITS-1:0] w;
        logic [N_BITS-1:0] n;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests;
    int   n_fail;

    an_encoder_52bits dut (
        .clk       (clk),
        .rst       (rst),
`ifdef ERR_INJ_EN
        .err_en    (err_en),
        .err_pos   (err_pos),
        .err_sign  (err_sign),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .N         (N),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .W         (W),
        .N_out     (N_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W_BITS-1:0] ref_w(input logic [N_BITS-1:0] n);
        logic [W_BITS-1:0] a_ext;
        logic [W_BITS-1:0] n_ext;
        a_ext = 69'd50861;
        n_ext = {16'd0, n};
        return a_ext * n_ext;
    endfunction

    function automatic logic [W_BITS-1:0] ref_inj(input logic [W_BITS-1:0] base, input logic en,
                                                  input logic [L_BITS-1:0] pos, input logic sgn);
        logic [W_BITS-1:0] e;
        if (!en || (int'(pos) >= 69)) return base;
        e = '0;
        e[pos] = 1'b1;
        return sgn ? base + e : base - e;
    endfunction

    task automatic check(input string name, input logic [W_BITS-1:0] act, input logic [W_BITS-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [W_BITS-1:0] w, input logic [N_BITS-1:0] n);
        exp_t e;
        e.w = w;
        e.n = n;
        sb_q.push_back(e);
    endtask

    // Monitor: a transfer happens on the edge after a negedge that sees valid && ready.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got W=0x%0h expected no output", W);
                end else begin
                    e = sb_q.pop_front();
                    check("W", W, e.w);
                    check("N_out", W_BITS'(N_out), W_BITS'(e.n));
                end
            end
        end
    end

    task automatic accept(input logic [N_BITS-1:0] n, input logic en, input logic [L_BITS-1:0] pos,
                          input logic sgn);
        check("ready_before_accept", W_BITS'(in_ready), W_BITS'(1));
        N        = n;
        err_en   = en;
        err_pos  = pos;
        err_sign = sgn;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        err_en   = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        while (!in_ready && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("return_to_ready", W_BITS'(in_ready), W_BITS'(1));
    endtask

    task automatic run_word(input logic [N_BITS-1:0] n, input logic en, input logic [L_BITS-1:0] pos,
                            input logic sgn, input logic [W_BITS-1:0] exp);
        int lat;
        push_exp(exp, n);
        accept(n, en, pos, sgn);
        wait_out(lat);
        check("latency", W_BITS'(lat), W_BITS'(17));
        wait_idle();
    endtask

    initial begin
        logic [W_BITS-1:0] w0;
        logic [N_BITS-1:0] n0;
        logic [N_BITS-1:0] rn;
        logic [L_BITS-1:0] rp;
        logic              rs;
        logic              stable;
        logic              seen;
        int                lat;

        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        N         = '0;
        out_ready = 1'b1;
        err_en    = 1'b0;
        err_pos   = '0;
        err_sign  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", W_BITS'(in_ready), W_BITS'(1));
        check("reset_out_valid", W_BITS'(out_valid), W_BITS'(0));
        check("reset_W", W, W_BITS'(0));
        check("reset_N_out", W_BITS'(N_out), W_BITS'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed products
        run_word(53'd1, 1'b0, 7'd0, 1'b0, 69'd50861);
        run_word(53'd0, 1'b0, 7'd0, 1'b0, 69'd0);
        run_word({N_BITS{1'b1}}, 1'b0, 7'd0, 1'b0, ref_w({N_BITS{1'b1}}));
        run_word(53'h10_0000_0000_0000, 1'b0, 7'd0, 1'b0, ref_w(53'h10_0000_0000_0000));
        run_word(53'd2, 1'b0, 7'd0, 1'b0, 69'd101722);

`ifdef ERR_INJ_EN
        run_word(53'd5, 1'b1, 7'd3, 1'b1, 69'd254313);
        run_word(53'd5, 1'b1, 7'd0, 1'b0, 69'd254304);
        run_word(53'd5, 1'b1, 7'd69, 1'b1, 69'd254305);
        run_word(53'd5, 1'b0, 7'd3, 1'b1, 69'd254305);
        w0 = '0;
        w0 = w0 - 69'd16;
        run_word(53'd0, 1'b1, 7'd4, 1'b0, w0);
        run_word(53'd1, 1'b1, 7'd68, 1'b1, 69'd50861 + {1'b1, 68'd0});
`else
        run_word(53'd5, 1'b1, 7'd3, 1'b1, 69'd254305);
`endif

        // Backpressure: hold 10 cycles with a pending input, then accept right after release
        out_ready = 1'b0;
        push_exp(ref_w(53'd7), 53'd7);
        N        = 53'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        N = 53'd9;
        check("busy_after_accept", W_BITS'(in_ready), W_BITS'(0));
        wait_out(lat);
        check("hold_latency", W_BITS'(lat), W_BITS'(17));
        w0     = W;
        n0     = N_out;
        stable = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (W !== w0 || N_out !== n0 || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
        end
        check("hold_stable", W_BITS'(stable), W_BITS'(1));
        check("hold_W", W, 69'd356027);
        push_exp(ref_w(53'd9), 53'd9);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_in_ready", W_BITS'(in_ready), W_BITS'(1));
        check("release_out_valid", W_BITS'(out_valid), W_BITS'(0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("second_accept", W_BITS'(in_ready), W_BITS'(0));
        wait_out(lat);
        check("second_latency", W_BITS'(lat), W_BITS'(17));
        wait_idle();

        // Reset mid-multiply discards the partial product
        accept(53'd3, 1'b0, 7'd0, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_in_ready", W_BITS'(in_ready), W_BITS'(1));
        check("midrst_out_valid", W_BITS'(out_valid), W_BITS'(0));
        check("midrst_W", W, W_BITS'(0));
        check("midrst_N_out", W_BITS'(N_out), W_BITS'(0));
        seen = 1'b0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_output", W_BITS'(seen), W_BITS'(0));
        run_word(53'd2, 1'b0, 7'd0, 1'b0, 69'd101722);

        // Random words against the reference model
        for (int i = 0; i < 8; i++) begin
            rn = N_BITS'({$urandom(), $urandom()});
            rp = L_BITS'($urandom_range(0, 72));
            rs = 1'($urandom_range(0, 1));
`ifdef ERR_INJ_EN
            run_word(rn, 1'b1, rp, rs, ref_inj(ref_w(rn), 1'b1, rp, rs));
`else
            run_word(rn, 1'b1, rp, rs, ref_w(rn));
`endif
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", W_BITS'(sb_q.size()), W_BITS'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
